// File: rtl/os_clmul_pkg.sv
// Shared types and constants for the Karatsuba carry-less multiply sequencer.
// Imported by the sequencer top and its digit-step engine.
package os_clmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int HALF_W = 32;
  localparam int PROD_W = 63;
  localparam int OP_W   = 64;

  localparam logic [1:0] SUB_LO  = 2'd0;
  localparam logic [1:0] SUB_MID = 2'd1;
  localparam logic [1:0] SUB_HI  = 2'd2;

endpackage

// File: rtl/clmul_digit_step.sv
// Combinational carry-less product of a 32-bit word and one DIGIT-bit slice.
// The caller shifts and folds the partial product into its accumulator.
module clmul_digit_step
  import os_clmul_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [HALF_W-1:0]       i_x,
  input  logic [DIGIT-1:0]        i_y,
  output logic [HALF_W+DIGIT-2:0] o_p
);

  localparam int PW = HALF_W + DIGIT - 1;

  // XOR together shifted copies of X for every set bit of the slice
  always_comb begin
    o_p = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i_y[i]) o_p = o_p ^ ((PW)'(i_x) << i);
    end
  end

endmodule

// File: rtl/clmul_kara_seq.sv
// Sequencer for the three Karatsuba sub-products of a 64x64 GF(2) multiply,
// time-sharing one 32xDIGIT carry-less engine across lo, mid and hi.
module clmul_kara_seq
  import os_clmul_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_z0,
  output logic [PROD_W-1:0] out_z1,
  output logic [PROD_W-1:0] out_z2,
  output logic              busy
);

  localparam int N   = HALF_W / DIGIT;
  localparam int SW  = (N > 1) ? $clog2(N) : 1;
  localparam int PPW = HALF_W + DIGIT - 1;

  state_t r_state;
  state_t w_state_nxt;

  logic [SW-1:0]     r_step;
  logic [1:0]        r_sub;
  logic [OP_W-1:0]   r_a;
  logic [OP_W-1:0]   r_b;
  logic [PROD_W-1:0] r_acc;
  logic [PROD_W-1:0] r_z0;
  logic [PROD_W-1:0] r_z1;
  logic [PROD_W-1:0] r_z2;

  logic              w_accept;
  logic              w_last;
  logic [5:0]        w_shamt;
  logic [HALF_W-1:0] w_x;
  logic [HALF_W-1:0] w_y;
  logic [DIGIT-1:0]  w_y_dig;
  logic [PPW-1:0]    w_pp;
  logic [PROD_W-1:0] w_acc_nxt;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_step == SW'(N - 1));
  assign w_shamt  = 6'(r_step) * 6'(DIGIT);

  // Operand halves for the sub-product currently being built
  always_comb begin
    w_x = '0;
    w_y = '0;
    unique case (r_sub)
      SUB_LO: begin
        w_x = r_a[HALF_W-1:0];
        w_y = r_b[HALF_W-1:0];
      end
      SUB_MID: begin
        w_x = r_a[HALF_W-1:0] ^ r_a[OP_W-1:HALF_W];
        w_y = r_b[HALF_W-1:0] ^ r_b[OP_W-1:HALF_W];
      end
      SUB_HI: begin
        w_x = r_a[OP_W-1:HALF_W];
        w_y = r_b[OP_W-1:HALF_W];
      end
      default: begin
        w_x = '0;
        w_y = '0;
      end
    endcase
  end

  assign w_y_dig = DIGIT'(w_y >> w_shamt);

  clmul_digit_step #(
    .DIGIT (DIGIT)
  ) u_step (
    .i_x (w_x),
    .i_y (w_y_dig),
    .o_p (w_pp)
  );

  assign w_acc_nxt = r_acc ^ (PROD_W'(w_pp) << w_shamt);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_state_nxt = MUL;
      MUL:  if (w_last && r_sub == SUB_HI) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = in_valid ? MUL : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      IDLE: in_ready = 1'b1;
      MUL:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand capture, digit accumulation and result write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_step <= '0;
      r_sub  <= SUB_LO;
      r_z0   <= '0;
      r_z1   <= '0;
      r_z2   <= '0;
    end else if (w_accept) begin
      r_a    <= in_a;
      r_b    <= in_b;
      r_acc  <= '0;
      r_step <= '0;
      r_sub  <= SUB_LO;
    end else if (r_state == MUL) begin
      if (w_last) begin
        r_acc  <= '0;
        r_step <= '0;
        r_sub  <= (r_sub == SUB_HI) ? SUB_LO : r_sub + 2'd1;
        unique case (r_sub)
          SUB_LO:  r_z0 <= w_acc_nxt;
          SUB_MID: r_z1 <= w_acc_nxt;
          SUB_HI:  r_z2 <= w_acc_nxt;
          default: r_z2 <= r_z2;
        endcase
      end else begin
        r_acc  <= w_acc_nxt;
        r_step <= r_step + 1'b1;
      end
    end
  end

  assign out_z0 = r_z0;
  assign out_z1 = r_z1;
  assign out_z2 = r_z2;

endmodule

// File: tb/tb_clmul_kara_seq.sv
// Directed and random checks of clmul_kara_seq for DIGIT = 1, 4 and 32.
// Reference products come from a bit-by-bit polynomial multiply.
module tb_clmul_kara_seq;

  localparam int DG [3] = '{1, 4, 32};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        iv   [3];
  logic        ordy [3];
  logic        irdy [3];
  logic        ov   [3];
  logic        bsy  [3];
  logic [62:0] z0   [3];
  logic [62:0] z1   [3];
  logic [62:0] z2   [3];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  clmul_kara_seq #(.DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_a(in_a), .in_b(in_b),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_z0(z0[0]), .out_z1(z1[0]), .out_z2(z2[0]),
    .busy(bsy[0])
  );

  clmul_kara_seq #(.DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_a(in_a), .in_b(in_b),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_z0(z0[1]), .out_z1(z1[1]), .out_z2(z2[1]),
    .busy(bsy[1])
  );

  clmul_kara_seq #(.DIGIT(32)) u_d32 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(irdy[2]),
    .in_a(in_a), .in_b(in_b),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_z0(z0[2]), .out_z1(z1[2]), .out_z2(z2[2]),
    .busy(bsy[2])
  );

  function automatic logic [62:0] cl(logic [31:0] a, logic [31:0] b);
    logic [62:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        r[i+j] = r[i+j] ^ (a[i] & b[j]);
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(int k, logic [63:0] a, logic [63:0] b);
    in_a  = a;
    in_b  = b;
    iv[k] = 1'b1;
    tick();
    iv[k] = 1'b0;
  endtask

  task automatic wait_valid(int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic chk_model(string tag, int k, logic [63:0] a, logic [63:0] b);
    chk({tag, ".z0"}, {1'b0, z0[k]}, {1'b0, cl(a[31:0], b[31:0])});
    chk({tag, ".z1"}, {1'b0, z1[k]},
        {1'b0, cl(a[31:0] ^ a[63:32], b[31:0] ^ b[63:32])});
    chk({tag, ".z2"}, {1'b0, z2[k]}, {1'b0, cl(a[63:32], b[63:32])});
  endtask

  task automatic job(string tag, logic [63:0] a, logic [63:0] b,
                     logic [62:0] e0, logic [62:0] e1, logic [62:0] e2);
    int lat;
    start(1, a, b);
    wait_valid(1, lat);
    chk({tag, ".lat"}, 64'(lat), 64'd24);
    chk({tag, ".z0"}, {1'b0, z0[1]}, {1'b0, e0});
    chk({tag, ".z1"}, {1'b0, z1[1]}, {1'b0, e1});
    chk({tag, ".z2"}, {1'b0, z2[1]}, {1'b0, e2});
    tick();
    chk({tag, ".vdrop"}, 64'(ov[1]), 64'd0);
  endtask

  initial begin
    logic [63:0] ops [4];
    logic [63:0] sa;
    logic [63:0] sb;
    logic [62:0] s0;
    int lat;

    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
    end

    #2;
    chk("rst.ov", 64'(ov[1]), 64'd0);
    chk("rst.busy", 64'(bsy[1]), 64'd0);
    chk("rst.z0", {1'b0, z0[1]}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst.irdy", 64'(irdy[1]), 64'd1);

    // 1: single-bit operands, with busy/in_ready during MUL
    in_a  = 64'd1;
    in_b  = 64'd1;
    iv[1] = 1'b1;
    tick();
    iv[1] = 1'b0;
    chk("t1.busy", 64'(bsy[1]), 64'd1);
    chk("t1.irdy", 64'(irdy[1]), 64'd0);
    wait_valid(1, lat);
    chk("t1.lat", 64'(lat), 64'd24);
    chk("t1.z0", {1'b0, z0[1]}, 64'd1);
    chk("t1.z1", {1'b0, z1[1]}, 64'd1);
    chk("t1.z2", {1'b0, z2[1]}, 64'd0);
    tick();
    chk("t1.vdrop", 64'(ov[1]), 64'd0);
    chk("t1.idle", 64'(irdy[1]), 64'd1);

    // 2 and 3: structured operands
    job("t2", 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
        63'd1, 63'd0, 63'd1);
    job("t3", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
        63'h5555_5555_5555_5555, 63'h5555_5555_5555_5555, 63'd0);

    // 4: backpressure in DONE, in_valid pulses ignored
    sa = {$urandom, $urandom};
    sb = {$urandom, $urandom};
    ordy[1] = 1'b0;
    start(1, sa, sb);
    wait_valid(1, lat);
    chk("t4.lat", 64'(lat), 64'd24);
    s0 = z0[1];
    for (int c = 0; c < 5; c++) begin
      chk("t4.irdy", 64'(irdy[1]), 64'd0);
      in_a  = {$urandom, $urandom};
      in_b  = {$urandom, $urandom};
      iv[1] = c[0];
      tick();
      chk("t4.ov", 64'(ov[1]), 64'd1);
      chk("t4.z0hold", {1'b0, z0[1]}, {1'b0, s0});
    end
    iv[1] = 1'b0;
    chk_model("t4", 1, sa, sb);
    ordy[1] = 1'b1;
    tick();
    chk("t4.vdrop", 64'(ov[1]), 64'd0);
    chk("t4.busy", 64'(bsy[1]), 64'd0);
    chk("t4.irdy1", 64'(irdy[1]), 64'd1);

    // 5: back-to-back with accept in the DONE cycle
    for (int j = 0; j < 4; j++) ops[j] = {$urandom, $urandom};
    in_a  = ops[0];
    in_b  = ~ops[0];
    iv[1] = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      in_a = ops[j+1];
      in_b = ~ops[j+1];
      wait_valid(1, lat);
      chk("t5.lat", 64'(lat), 64'd24);
      chk_model("t5", 1, ops[j], ~ops[j]);
      if (j == 2) iv[1] = 1'b0;
      tick();
      chk("t5.vlow", 64'(ov[1]), 64'd0);
    end
    chk("t5.idle", 64'(bsy[1]), 64'd0);

    // 6: reset mid-job
    start(1, {$urandom, $urandom}, {$urandom, $urandom});
    for (int c = 0; c < 10; c++) tick();
    chk("t6.busy0", 64'(bsy[1]), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6.ov", 64'(ov[1]), 64'd0);
    chk("t6.busy", 64'(bsy[1]), 64'd0);
    chk("t6.z0", {1'b0, z0[1]}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6.irdy", 64'(irdy[1]), 64'd1);
    job("t6", 64'd3, 64'd5, 63'hF, 63'hF, 63'd0);

    // Random vectors on every DIGIT build
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 6; v++) begin
        sa = {$urandom, $urandom};
        sb = {$urandom, $urandom};
        start(k, sa, sb);
        wait_valid(k, lat);
        chk($sformatf("rnd%0d.lat", DG[k]), 64'(lat), 64'(96 / DG[k]));
        chk_model($sformatf("rnd%0d", DG[k]), k, sa, sb);
        tick();
        chk($sformatf("rnd%0d.vdrop", DG[k]), 64'(ov[k]), 64'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
